mux_scan_sequencer: RTL
=======================

# mux_scan_sequencer

Channel scanner that sits directly upstream of the 4:1 mux (`mux_4x1`) and drives its 2-bit select. It steps the select through channels 0–3, waits a programmable settle time on each channel, and samples the mux output bit. It assembles the four samples into a 4-bit word and presents that word on a valid/ready output handshake. This turns the combinational mux into a sequential bit-serial-to-parallel capture path.

## Interface
Parameters:
- `SETTLE`, default 1: idle cycles per channel between the select change and the sample. Legal range is 0–15.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: scan request. Sampled only in IDLE.
- `sel`, output, 2: registered select, wired to the mux `S` input.
- `y_in`, input, 1: the mux `Y` output.
- `data`, output, 4: captured word. `data[n]` holds the sample taken with `sel==n`.
- `valid`, output, 1: `data` is complete and stable.
- `ready`, input, 1: downstream accepts `data` on any edge where `valid && ready`.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- FSM states are IDLE, SETTLE, SAMPLE and HOLD, plus a 4-bit settle counter `cnt`.
- **Reset** (`rst` high at an edge):
  - state becomes IDLE;
  - `sel`=0, `cnt`=0, `data`=4'b0000, `valid`=0, `busy`=0.
  - Reset takes priority over every other event, including in the middle of a scan or in HOLD.
- **IDLE**, `start`=1:
  - `sel`<=0 and `cnt`<=0;
  - next state is SETTLE if `SETTLE`>0, otherwise SAMPLE.
- **SETTLE**:
  - `cnt` increments on each edge;
  - when `cnt==SETTLE-1`, go to SAMPLE and clear `cnt`.
- **SAMPLE** (lasts one cycle):
  - `data[sel]`<=`y_in`.
  - If `sel`<3: `sel`<=`sel`+1, and the next state is SETTLE, or SAMPLE when `SETTLE`=0.
  - If `sel`==3: `valid`<=1 and go to HOLD. `sel` stays at 3; it does not wrap until the next scan starts.
- **HOLD**:
  - `data` and `sel` are frozen.
  - On an edge with `ready`=1: `valid`<=0, and the state goes to IDLE (or restarts a scan; see Configuration).
- `start` is ignored outside IDLE. It is not queued.
- `data` is written only in SAMPLE. Bits not yet rewritten in the current scan keep their previous-scan values. Downstream may only use `data` while `valid`=1.

## Timing
- Each channel occupies `SETTLE`+1 cycles.
- Start is accepted at edge E0. `valid` rises at edge E0 + 4·(`SETTLE`+1):
  - `SETTLE`=1: 8 cycles;
  - `SETTLE`=0: 4 cycles.
- `sel` changes only on the edge that leaves SAMPLE or IDLE. `y_in` is therefore sampled at least `SETTLE`+1 edges after its select changed.
- Handshake:
  - `valid` stays high, and `data` stays stable, until the edge where `ready`=1.
  - `ready` held permanently high costs exactly 1 HOLD cycle.
  - `ready` is ignored when `valid`=0.
- `busy` is a registered output: it goes high on E0 and low on the acceptance edge, when returning to IDLE.
- Back-to-back scans (non-continuous build): the acceptance edge returns to IDLE. The earliest next `start` is sampled one edge later.

## Configuration
- Macro: `MUX_SCAN_CONTINUOUS_EN`.
- **Defined:** the HOLD acceptance edge goes directly to the first scan state, with `sel`<=0 and `cnt`<=0; it does not go to IDLE.
  - `busy` stays high.
  - `start` is needed only for the first scan after reset.
  - Word rate is one word per 4·(`SETTLE`+1)+1 cycles with `ready` held high.
- **Undefined:** every scan needs a `start` sampled in IDLE, as described in Operation.

## Test plan
- **Basic scan:** mux model with I=4'b1010, `SETTLE`=1, `ready`=1, pulse `start` → `sel` steps 0,1,2,3, each held 2 cycles. `valid` rises 8 cycles after `start` with `data`=4'b1010. `valid` drops 1 cycle later.
- **Zero settle:** `SETTLE`=0, I=4'b0110 → `valid` rises 4 cycles after `start` with `data`=4'b0110, and `sel` changes every cycle.
- **Backpressure:** I=4'b1001, `ready`=0 for 5 cycles after `valid` rises → `valid`=1, `data`=4'b1001 and `sel`=3 all stable for those 5 cycles. Raising `ready` clears `valid` on the next edge.
- **Start while busy:** pulse `start` again 3 cycles into a scan → no restart, and `valid` timing is unchanged at 8 cycles. Change I mid-scan from 4'b0001 to 4'b1110 after channel 0 has been sampled → `data`=4'b1111.
- **Reset mid-scan:** assert `rst` for 1 cycle while `sel`=2 → next cycle `sel`=0, `data`=0, `valid`=0, `busy`=0. A fresh `start` then completes normally.
- **Continuous build** (`MUX_SCAN_CONTINUOUS_EN` defined, `SETTLE`=1, `ready`=1): one `start` → `valid` pulses every 9 cycles and `busy` stays high. Changing I to 4'b0101 is reflected in the next complete word.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Scans the four inputs of a 4:1 mux, settling on each select before sampling Y,
// and presents the assembled 4-bit word on a valid/ready handshake.
// Optional build macro: MUX_SCAN_CONTINUOUS_EN (rescan immediately after each accepted word).
module mux_scan_sequencer #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [1:0] sel,
    input  logic       y_in,
    output logic [3:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // With no settle time every channel goes straight to its sample cycle.
    localparam state_t     FIRST_ST    = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_r;
    state_t     state_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;
    logic [1:0] sel_s;
    logic [3:0] data_s;
    logic       valid_s;
    logic       busy_s;

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        sel_s   = sel;
        data_s  = data;
        valid_s = valid;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    sel_s   = 2'd0;
                    cnt_s   = 4'd0;
                    state_s = FIRST_ST;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    cnt_s   = 4'd0;
                    state_s = ST_SAMPLE;
                end else begin
                    cnt_s   = cnt_r + 4'd1;
                end
            end
            ST_SAMPLE: begin
                data_s[sel] = y_in;
                // sel parks at 3 through HOLD; it only wraps when a new scan begins.
                if (sel != 2'd3) begin
                    sel_s   = sel + 2'd1;
                    state_s = FIRST_ST;
                end else begin
                    valid_s = 1'b1;
                    state_s = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ready) begin
                    valid_s = 1'b0;
`ifdef MUX_SCAN_CONTINUOUS_EN
                    sel_s   = 2'd0;
                    cnt_s   = 4'd0;
                    state_s = FIRST_ST;
`else
                    state_s = ST_IDLE;
`endif
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            sel     <= 2'd0;
            data    <= 4'b0000;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            sel     <= sel_s;
            data    <= data_s;
            valid   <= valid_s;
            busy    <= busy_s;
        end
    end

endmodule
